// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - single-issue instruction fetch sequencer with misalign trap
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        NextPCSrc,
  input  logic [31:0] BrTarget,
  input  logic        BrValid,
  output logic        IReq,
  output logic [31:0] IAddr,
  input  logic        IReady,
  input  logic [31:0] IData,
  output logic [31:0] Inst,
  output logic        InstValid,
  output logic [31:0] PC,
  output logic        MisalignTrap,
  output logic [31:0] RetireCount
);

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    TRAP  = 2'd3
  } state_t;

  state_t state;

  // The memory address always tracks the PC register; PC only ever holds
  // aligned values because misaligned redirects are trapped, not taken.
  assign IAddr = PC;

  // Fetch/hold/resolve sequencer; all outputs are registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= START;
      PC           <= RESET_PC;
      Inst         <= 32'h0000_0000;
      InstValid    <= 1'b0;
      IReq         <= 1'b0;
      MisalignTrap <= 1'b0;
      RetireCount  <= 32'h0000_0000;
    end else begin
      case (state)
        START: begin
          state <= FETCH;
          IReq  <= 1'b1;
        end

        FETCH: begin
          if (IReady) begin
            Inst      <= IData;
            IReq      <= 1'b0;
            InstValid <= 1'b1;
            state     <= HOLD;
          end
        end

        HOLD: begin
          if (BrValid) begin
            InstValid <= 1'b0;
            if (!NextPCSrc) begin
              PC          <= PC + 32'd4;
              RetireCount <= RetireCount + 32'd1;
              IReq        <= 1'b1;
              state       <= FETCH;
            end else if (BrTarget[1:0] == 2'b00) begin
              PC          <= BrTarget;
              RetireCount <= RetireCount + 32'd1;
              IReq        <= 1'b1;
              state       <= FETCH;
            end else begin
              // PC keeps the faulting instruction's address for the handler
              MisalignTrap <= 1'b1;
              state        <= TRAP;
            end
          end
        end

        TRAP: begin
          state <= TRAP;
        end

        default: begin
          state <= START;
          IReq  <= 1'b0;
        end
      endcase
    end
  end

endmodule
